// File: rtl/conv_window_scheduler.sv
// ---------------------------------------------------------------------------
// conv_window_scheduler
//
// Read-side sequencer for the convolution line buffer. On each completed
// input row (row_done with row_ready high) it sweeps the readable rows column
// by column. It issues one SRAM read per column and flags each assembled
// KER_SIZE x KER_SIZE window for the MAC array, honouring the horizontal
// stride and downstream backpressure. It holds off the upstream writer while
// a further row is already queued.
//
// Ports
//   clk        : clock, all logic on posedge
//   rstn       : asynchronous active-low reset
//   flush      : synchronous abort back to IDLE (highest priority)
//   row_done   : line buffer finished writing a row (pulse)
//   row_ready  : line buffer holds KER_SIZE valid rows at the right stride
//   out_ready  : MAC array accepts the presented window
//   rd_en      : read strobe to the KER_SIZE read banks
//   rd_addr    : column address of the read
//   col_shift  : SRAM data valid, shift into window registers
//   win_valid  : a complete window is presented
//   win_col    : start column of the presented window
//   win_first  : presented window is the first of the row
//   win_last   : presented window is the last of the row
//   in_stall   : upstream must not assert row_done
//   busy       : scheduler is not idle
//   overflow   : sticky, row_done seen while in_stall was high
// ---------------------------------------------------------------------------
module conv_window_scheduler #(
    parameter int KER_SIZE    = 3,
    parameter int STRIDE      = 1,
    parameter int INPUT_X_DIM = 28,
    parameter int AW          = 5
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          flush,
    input  logic          row_done,
    input  logic          row_ready,
    input  logic          out_ready,
    output logic          rd_en,
    output logic [AW-1:0] rd_addr,
    output logic          col_shift,
    output logic          win_valid,
    output logic [AW-1:0] win_col,
    output logic          win_first,
    output logic          win_last,
    output logic          in_stall,
    output logic          busy,
    output logic          overflow
);

    localparam int OUT_X = (INPUT_X_DIM - KER_SIZE) / STRIDE + 1;
    localparam int IW    = $clog2(OUT_X + 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SWEEP = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    localparam logic [AW-1:0] LAST_COL = AW'(INPUT_X_DIM - 1);
    localparam logic [AW:0]   KER_M1   = (AW + 1)'(KER_SIZE - 1);
    localparam logic [AW-1:0] STEP     = AW'(STRIDE);
    localparam logic [IW-1:0] WIN_END  = IW'(OUT_X);
    localparam logic [IW-1:0] WIN_LAST = IW'(OUT_X - 1);

    logic [1:0]    state;
    logic          pending;
    logic          rd_vld_p1;    // rd_en delayed by the SRAM read latency
    logic [AW-1:0] nxt_col;      // start column of the next window to emit
    logic [IW-1:0] win_idx;      // windows emitted so far in this row

    logic stall;
    logic last_rd;
    logic fire;
    logic accept_last;
    logic row_end;
    logic start;

    assign stall       = win_valid && !out_ready;
    assign rd_en       = (state == S_SWEEP) && !stall;
    assign last_rd     = rd_en && (rd_addr == LAST_COL);

    // A window is complete once the read of its rightmost column issues;
    // trailing columns beyond the last window never fire.
    assign fire        = rd_en && (win_idx != WIN_END) &&
                         ({1'b0, rd_addr} == ({1'b0, nxt_col} + KER_M1));
    assign accept_last = win_valid && win_last && out_ready;

    // The row is finished either when the last window is accepted in DRAIN,
    // or at the final read if every window is already out and accepted
    // (possible when the last window fired before the trailing columns).
    assign row_end     = ((state == S_DRAIN) && accept_last) || (last_rd && !fire);
    assign start       = ((state == S_IDLE) && row_done && row_ready) ||
                         (row_end && (pending || row_done));

    assign col_shift   = rd_vld_p1;
    assign in_stall    = pending;
    assign busy        = (state != S_IDLE);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= S_IDLE;
            pending   <= 1'b0;
            overflow  <= 1'b0;
            rd_vld_p1 <= 1'b0;
            rd_addr   <= '0;
            nxt_col   <= '0;
            win_idx   <= '0;
            win_valid <= 1'b0;
            win_col   <= '0;
            win_first <= 1'b0;
            win_last  <= 1'b0;
        end else if (flush) begin
            state     <= S_IDLE;
            pending   <= 1'b0;
            overflow  <= 1'b0;
            rd_vld_p1 <= 1'b0;
            rd_addr   <= '0;
            nxt_col   <= '0;
            win_idx   <= '0;
            win_valid <= 1'b0;
            win_col   <= '0;
            win_first <= 1'b0;
            win_last  <= 1'b0;
        end else begin
            // ---- read issue -> SRAM data valid (p1) ----
            rd_vld_p1 <= rd_en;

            // ---- window presentation ----
            if (fire) begin
                win_valid <= 1'b1;
                win_col   <= nxt_col;
                win_first <= (win_idx == '0);
                win_last  <= (win_idx == WIN_LAST);
                nxt_col   <= nxt_col + STEP;
                win_idx   <= win_idx + IW'(1);
            end else if (out_ready) begin
                win_valid <= 1'b0;
                win_first <= 1'b0;
                win_last  <= 1'b0;
            end

            // ---- sweep control ----
            if (start) begin
                state   <= S_SWEEP;
                rd_addr <= '0;
                nxt_col <= '0;
                win_idx <= '0;
            end else if (row_end) begin
                state   <= S_IDLE;
                rd_addr <= '0;
                nxt_col <= '0;
                win_idx <= '0;
            end else if (last_rd) begin
                state   <= S_DRAIN;
                rd_addr <= '0;
            end else if (rd_en) begin
                rd_addr <= rd_addr + AW'(1);
            end

            // ---- queued row bookkeeping ----
            if (row_end) begin
                pending <= 1'b0;
                if (row_done && pending)
                    overflow <= 1'b1;
            end else if ((state != S_IDLE) && row_done) begin
                if (pending)
                    overflow <= 1'b1;
                else
                    pending <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_conv_window_scheduler.sv
module tb_conv_window_scheduler;

    localparam int K = 3;
    localparam int X = 28;

    logic clk = 1'b0;
    logic rstn, flush, row_done, row_ready, out_ready;

    logic       rd_en     [2];
    logic [4:0] rd_addr   [2];
    logic       col_shift [2];
    logic       win_valid [2];
    logic [4:0] win_col   [2];
    logic       win_first [2];
    logic       win_last  [2];
    logic       in_stall  [2];
    logic       busy      [2];
    logic       overflow  [2];

    int checks = 0;
    int errors = 0;

    // scoreboard state, one slot per DUT (0: stride 1, 1: stride 2)
    int   exp_addr [2];
    int   exp_win  [2];
    logic prev_rd  [2];
    logic prev_fl;
    bit   sb_on;

    always #5 clk = ~clk;

    conv_window_scheduler #(.KER_SIZE(K), .STRIDE(1), .INPUT_X_DIM(X), .AW(5)) u0 (
        .clk(clk), .rstn(rstn), .flush(flush), .row_done(row_done), .row_ready(row_ready),
        .out_ready(out_ready), .rd_en(rd_en[0]), .rd_addr(rd_addr[0]), .col_shift(col_shift[0]),
        .win_valid(win_valid[0]), .win_col(win_col[0]), .win_first(win_first[0]),
        .win_last(win_last[0]), .in_stall(in_stall[0]), .busy(busy[0]), .overflow(overflow[0]));

    conv_window_scheduler #(.KER_SIZE(K), .STRIDE(2), .INPUT_X_DIM(X), .AW(5)) u1 (
        .clk(clk), .rstn(rstn), .flush(flush), .row_done(row_done), .row_ready(row_ready),
        .out_ready(out_ready), .rd_en(rd_en[1]), .rd_addr(rd_addr[1]), .col_shift(col_shift[1]),
        .win_valid(win_valid[1]), .win_col(win_col[1]), .win_first(win_first[1]),
        .win_last(win_last[1]), .in_stall(in_stall[1]), .busy(busy[1]), .overflow(overflow[1]));

    function automatic int strd(input int d);
        return (d == 0) ? 1 : 2;
    endfunction

    function automatic int ox(input int d);
        return (X - K) / strd(d) + 1;
    endfunction

    // cycle (relative to trigger) of the last window with no backpressure
    function automatic int lastwin(input int d);
        return K + 1 + (ox(d) - 1) * strd(d);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic monitor();
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("col_shift_s%0d", strd(d)), col_shift[d], prev_rd[d] && !prev_fl);
            if (win_valid[d] && !out_ready)
                chk($sformatf("stall_rd_en_s%0d", strd(d)), rd_en[d], 0);
            if (sb_on) begin
                if (rd_en[d]) begin
                    chk($sformatf("rd_addr_seq_s%0d", strd(d)), rd_addr[d], exp_addr[d]);
                    exp_addr[d]++;
                end
                if (win_valid[d] && out_ready) begin
                    chk($sformatf("win_col_seq_s%0d", strd(d)), win_col[d], exp_win[d] * strd(d));
                    chk($sformatf("win_first_seq_s%0d", strd(d)), win_first[d], exp_win[d] == 0);
                    chk($sformatf("win_last_seq_s%0d", strd(d)), win_last[d], exp_win[d] == ox(d) - 1);
                    exp_win[d]++;
                end
            end
            prev_rd[d] = rd_en[d];
        end
        prev_fl = flush;
    endtask

    task automatic drive(input logic rd, input logic rr, input logic ordy, input logic fl);
        row_done  = rd;
        row_ready = rr;
        out_ready = ordy;
        flush     = fl;
    endtask

    task automatic step(input logic rd, input logic rr, input logic ordy, input logic fl);
        @(posedge clk);
        #1;
        drive(rd, rr, ordy, fl);
        #1;
        monitor();
    endtask

    task automatic sb_reset();
        for (int d = 0; d < 2; d++) begin
            exp_addr[d] = 0;
            exp_win[d]  = 0;
        end
    endtask

    task automatic chk_idle(input string tag);
        for (int d = 0; d < 2; d++) begin
            chk({tag, "_rd_en"},     rd_en[d],     0);
            chk({tag, "_rd_addr"},   rd_addr[d],   0);
            chk({tag, "_col_shift"}, col_shift[d], 0);
            chk({tag, "_win_valid"}, win_valid[d], 0);
            chk({tag, "_win_col"},   win_col[d],   0);
            chk({tag, "_win_first"}, win_first[d], 0);
            chk({tag, "_win_last"},  win_last[d],  0);
            chk({tag, "_in_stall"},  in_stall[d],  0);
            chk({tag, "_busy"},      busy[d],      0);
            chk({tag, "_overflow"},  overflow[d],  0);
        end
    endtask

    // One row with out_ready either following a fixed backpressure episode
    // (hold win_col=4 for 5 cycles) or random.
    task automatic run_sweep(input bit bp_mode);
        int   hold = 0;
        int   cyc  = 0;
        bit   acc4 = 0;
        bit   done = 0;
        logic ordy;
        logic [4:0] frozen = '0;
        sb_reset();
        sb_on = 1;
        step(1, 1, 1, 0);
        while (!done && cyc < 400) begin
            @(posedge clk);
            #1;
            if (bp_mode)
                ordy = !(win_valid[0] && win_col[0] == 5'd4 && hold < 5);
            else
                ordy = ($urandom_range(0, 9) < 6);
            drive(0, $urandom_range(0, 1), ordy, 0);
            #1;
            if (bp_mode) begin
                if (acc4) begin
                    chk("bp_resume_valid", win_valid[0], 1);
                    chk("bp_resume_col",   win_col[0],   5);
                    acc4 = 0;
                end
                if (!ordy) begin
                    if (hold == 0) frozen = rd_addr[0];
                    chk("bp_rd_en",     rd_en[0],     0);
                    chk("bp_rd_addr",   rd_addr[0],   frozen);
                    chk("bp_win_valid", win_valid[0], 1);
                    chk("bp_win_col",   win_col[0],   4);
                    hold++;
                end else if (win_valid[0] && win_col[0] == 5'd4 && hold == 5) begin
                    acc4 = 1;
                end
            end
            monitor();
            cyc++;
            if (cyc > 1 && !busy[0] && !busy[1]) done = 1;
        end
        chk("sweep_timeout", done, 1);
        if (bp_mode) chk("bp_hold_cycles", hold, 5);
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("win_count_s%0d", strd(d)),  exp_win[d],  ox(d));
            chk($sformatf("read_count_s%0d", strd(d)), exp_addr[d], X);
        end
        sb_on = 0;
    endtask

    initial begin
        int k;
        int s;
        bit wv;
        rstn = 1'b1;
        drive(0, 0, 0, 0);
        prev_fl = 1'b0;
        sb_on   = 0;
        for (int d = 0; d < 2; d++) prev_rd[d] = 1'b0;
        sb_reset();

        // reset values
        #1 rstn = 1'b0;
        step(0, 0, 0, 0);
        chk_idle("reset");
        step(0, 0, 1, 0);
        rstn = 1'b1;
        step(0, 0, 1, 0);
        chk_idle("post_reset");

        // single trigger, no backpressure: exact cycle timing
        sb_reset();
        sb_on = 1;
        step(1, 1, 1, 0);
        for (int n = 1; n <= 32; n++) begin
            step(0, $urandom_range(0, 1), 1, 0);
            for (int d = 0; d < 2; d++) begin
                s  = strd(d);
                k  = n - K - 1;
                wv = (k >= 0) && (k % s == 0) && (k / s < ox(d));
                chk($sformatf("t_rd_en_s%0d_n%0d", s, n), rd_en[d], (n >= 1 && n <= X));
                if (n >= 1 && n <= X)
                    chk($sformatf("t_rd_addr_s%0d_n%0d", s, n), rd_addr[d], n - 1);
                chk($sformatf("t_win_valid_s%0d_n%0d", s, n), win_valid[d], wv);
                if (wv) chk($sformatf("t_win_col_s%0d_n%0d", s, n), win_col[d], k);
                chk($sformatf("t_win_first_s%0d_n%0d", s, n), win_first[d], wv && k == 0);
                chk($sformatf("t_win_last_s%0d_n%0d", s, n), win_last[d], wv && (k / s == ox(d) - 1));
                chk($sformatf("t_busy_s%0d_n%0d", s, n), busy[d], (n <= lastwin(d)));
                chk($sformatf("t_in_stall_s%0d_n%0d", s, n), in_stall[d], 0);
            end
        end
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("t_win_count_s%0d", strd(d)),  exp_win[d],  ox(d));
            chk($sformatf("t_read_count_s%0d", strd(d)), exp_addr[d], X);
        end
        sb_on = 0;

        // backpressure episode, then randomized out_ready rows
        run_sweep(1);
        for (int r = 0; r < 3; r++) run_sweep(0);

        // second row_done mid-sweep, third sets overflow, then flush at rd_addr=10
        step(1, 1, 1, 0);
        for (int n = 1; n <= 42; n++) begin
            step((n == 5 || n == 10), 1, 1, (n == 40));
            if (n == 6)  chk("q_in_stall_set", in_stall[0], 1);
            if (n == 11) chk("q_overflow_set", overflow[0], 1);
            if (n == 29) begin
                chk("q_in_stall_hold", in_stall[0], 1);
                chk("q_last_s1",       win_last[0], 1);
                chk("q_s2_rd_en",      rd_en[1],    1);
                chk("q_s2_rd_addr",    rd_addr[1],  0);
                chk("q_s2_in_stall",   in_stall[1], 0);
            end
            if (n == 30) begin
                chk("q_rd_en",     rd_en[0],    1);
                chk("q_rd_addr",   rd_addr[0],  0);
                chk("q_busy",      busy[0],     1);
                chk("q_in_stall",  in_stall[0], 0);
                chk("q_overflow",  overflow[0], 1);
            end
            if (n == 40) chk("q_flush_addr", rd_addr[0], 10);
            if (n == 41) chk_idle("flush");
        end

        // row_done without row_ready in IDLE
        step(1, 0, 1, 0);
        for (int n = 0; n < 4; n++) begin
            step(0, 0, 1, 0);
            chk("norr_rd_en_s1", rd_en[0], 0);
            chk("norr_busy_s1",  busy[0],  0);
            chk("norr_rd_en_s2", rd_en[1], 0);
            chk("norr_busy_s2",  busy[1],  0);
        end

        // asynchronous reset mid-sweep
        step(1, 1, 1, 0);
        for (int n = 1; n <= 8; n++) step(0, 1, 1, 0);
        chk("mid_busy_before", busy[0], 1);
        #2 rstn = 1'b0;
        #1;
        chk_idle("async_reset");
        for (int d = 0; d < 2; d++) prev_rd[d] = 1'b0;
        step(0, 1, 1, 0);
        rstn = 1'b1;
        for (int n = 0; n < 10; n++) begin
            step(0, 1, 1, 0);
            chk("rel_win_valid_s1", win_valid[0], 0);
            chk("rel_busy_s1",      busy[0],      0);
            chk("rel_win_valid_s2", win_valid[1], 0);
            chk("rel_busy_s2",      busy[1],      0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
